// File: rtl/dmem_mmio.sv
// dmem_mmio: data-side memory for the single-cycle MIPS core.
//   addr[31]=0            -> word RAM (2**RAM_AW words, upper bits alias)
//   addr[31:4]==IO_BASE   -> I/O block: TXDATA push FIFO, STATUS, CYCLE, reserved
//   anything else         -> reads 0, writes ignored
// Optional feature macro: DMEM_MMIO_CYCLE_CNT_EN adds a free-running, loadable
// 32-bit cycle counter at offset 0x8. Without it, CYCLE reads 0.
// Read data is combinational; all state updates on the rising clock edge.
module dmem_mmio #(
   parameter int          RAM_AW  = 6,
   parameter int          FIFO_AW = 3,
   parameter logic [31:0] IO_BASE = 32'hFFFF0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic [31:0] addr,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        overflow
);

   localparam int             RAM_WORDS = 1 << RAM_AW;
   localparam int             DEPTH     = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0]   FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};
   localparam logic [FIFO_AW:0]   CNT_ZERO = {(FIFO_AW+1){1'b0}};
   localparam logic [FIFO_AW:0]   CNT_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
   localparam logic [FIFO_AW-1:0] PTR_ONE  = {{(FIFO_AW-1){1'b0}}, 1'b1};

   // Storage (never reset)
   logic [31:0] ram_mem  [0:RAM_WORDS-1];
   logic [31:0] fifo_mem [0:DEPTH-1];

   // FIFO control state
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]   count_q,  count_d;
   logic               overflow_q, overflow_d;

   // Decode
   logic [RAM_AW-1:0] ram_idx_s;
   logic              ram_sel_s, io_sel_s;
   logic [1:0]        io_off_s;
   logic              txdata_wr_s, status_wr_s;
   logic              full_s, empty_s, pop_s, push_ok_s, drop_s;
   logic [31:0]       status_s, cycle_rd_s;
   logic              unused_addr_s;

   assign ram_idx_s     = addr[RAM_AW+1:2];
   assign ram_sel_s     = ~addr[31];
   assign io_sel_s      = (addr[31:4] == IO_BASE[31:4]);
   assign io_off_s      = addr[3:2];
   assign unused_addr_s = ^addr[1:0];

   assign txdata_wr_s = memwrite & io_sel_s & (io_off_s == 2'd0);
   assign status_wr_s = memwrite & io_sel_s & (io_off_s == 2'd1);

   assign full_s    = (count_q == FULL_CNT);
   assign empty_s   = (count_q == CNT_ZERO);
   assign pop_s     = ~empty_s & out_ready;
   // A pop in the same cycle frees the slot the push needs, even when full.
   assign push_ok_s = txdata_wr_s & (~full_s | pop_s);
   assign drop_s    = txdata_wr_s & full_s & ~pop_s;

   assign status_s = {{(32-FIFO_AW-9){1'b0}}, count_q, 5'd0, overflow_q, full_s, empty_s};

   // Outputs are functions of flopped state only, so they move only on the clock edge.
   assign out_valid = ~empty_s;
   assign out_data  = fifo_mem[rd_ptr_q];
   assign overflow  = overflow_q;

   // Next-state for FIFO pointers, occupancy count and sticky overflow.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (push_ok_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      // A drop in the same cycle as a STATUS write keeps the flag set.
      if (drop_s) begin
         overflow_d = 1'b1;
      end else if (status_wr_s) begin
         overflow_d = 1'b0;
      end else begin
         overflow_d = overflow_q;
      end
   end

   // FIFO control registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q   <= {FIFO_AW{1'b0}};
         rd_ptr_q   <= {FIFO_AW{1'b0}};
         count_q    <= CNT_ZERO;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // RAM store port.
   always_ff @(posedge clk) begin
      if (memwrite && ram_sel_s) begin
         ram_mem[ram_idx_s] <= writedata;
      end
   end

   // FIFO storage write; when full with a simultaneous pop the head slot is reused.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         fifo_mem[wr_ptr_q] <= writedata;
      end
   end

`ifdef DMEM_MMIO_CYCLE_CNT_EN
   logic [31:0] cycle_q, cycle_d;
   logic        cycle_wr_s;

   assign cycle_wr_s = memwrite & io_sel_s & (io_off_s == 2'd2);
   assign cycle_rd_s = cycle_q;

   // Counter next value: a software load overrides the increment.
   always_comb begin
      cycle_d = cycle_q;
      if (cycle_wr_s) begin
         cycle_d = writedata;
      end else begin
         cycle_d = cycle_q + 32'd1;
      end
   end

   // Cycle counter register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cycle_q <= 32'd0;
      end else begin
         cycle_q <= cycle_d;
      end
   end
`else
   assign cycle_rd_s = 32'd0;
`endif

   // Combinational load data mux; reads have no side effects.
   always_comb begin
      readdata = 32'd0;
      if (ram_sel_s) begin
         readdata = ram_mem[ram_idx_s];
      end else if (io_sel_s) begin
         case (io_off_s)
            2'd1:    readdata = status_s;
            2'd2:    readdata = cycle_rd_s;
            default: readdata = 32'd0;
         endcase
      end else begin
         readdata = 32'd0;
      end
   end

endmodule
